ov7670_stream_gen: RTL and testbench
====================================

Name: ov7670_stream_gen

Overview:
Synthesizable OV7670 pixel-stream transmitter. It produces the camera-side signals (vsync, href, 8-bit px_data) that the capture path consumes.
- Output is RGB565 over two bytes per pixel, QCIF 176x144 by default.
- It drives the capture/RAM/VGA chain in simulation, and on board when no sensor is fitted.
- The consumer samples px_data/href/vsync on the same clk rising edge.

Parameters:
- H_ACT, 176: active pixels per line; each pixel is 2 bytes, so 352 byte cycles.
- V_ACT, 144: active lines per frame.
- H_BLANK, 144: href-low cycles after each line's active bytes.
- VS_LINES, 3: lines during which vsync is high.
- V_BP, 17: blank lines between vsync fall and the first active line.
- V_FP, 10: blank lines after the last active line.

Ports:
- clk, input, 1: byte clock; plays the role of the camera pclk.
- rst, input, 1: reset.
- enable, input, 1: start frames; when deasserted, the current frame finishes first.
- pattern_sel, input, 2: 0 colour bars, 1 solid, 2 horizontal gradient, 3 checkerboard.
- solid_rgb565, input, 16: colour used when pattern_sel=1.
- vsync, output, 1: frame sync, active high.
- href, output, 1: high during active bytes of a line.
- px_data, output, 8: pixel byte.
- frame_done, output, 1: one-cycle pulse on the last cycle of V_FP.
- frame_cnt, output, 16: completed frame count; wraps 0xFFFF->0.
- frame_sum, output, 16: per-frame byte checksum (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-high: clk, rst.
  - While rst=1: vsync=0, href=0, px_data=0, frame_done=0, frame_cnt=0, frame_sum=0, state=IDLE.
  - Reset mid-frame aborts the frame immediately; no frame_done is emitted.
- Timing:
  - LINE_T = 2*H_ACT + H_BLANK = 496 cycles.
  - Frame = (VS_LINES+V_BP+V_ACT+V_FP) * LINE_T = 174*496 = 86304 cycles.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP.
  - IDLE: all outputs 0. If enable=1 at a rising edge, go to VSYNC. vsync=1 is visible after that edge.
  - VSYNC: vsync=1 for VS_LINES*LINE_T cycles, then VBP.
  - VBP: V_BP*LINE_T cycles, all low, then ACTIVE.
  - ACTIVE: per line, href=1 for 2*H_ACT cycles, then href=0 for H_BLANK cycles. After V_ACT lines, go to VFP.
  - VFP: V_FP*LINE_T cycles. On the final cycle, frame_done=1 and frame_cnt increments. Next state is VSYNC if enable=1, else IDLE.
- Counters:
  - byte_x: 0..LINE_T-1.
  - line_y: counts lines within the state.
  - pixel x = byte_x>>1 while href=1.
- Byte order:
  - Even byte = RGB565[15:8] ({R4:0, G5:3}).
  - Odd byte = RGB565[7:0] ({G2:0, B4:0}).
  - px_data = 0 whenever href=0.
- Sampling:
  - pattern_sel and solid_rgb565 are sampled on entry to VSYNC and held for the whole frame. Mid-frame changes are ignored.
  - enable is sampled only in IDLE and on the last VFP cycle. Deasserting it mid-frame never truncates the frame.
- Patterns:
  - 0, colour bars: bar = x / (H_ACT/8), 22 px per bar. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. x beyond 8 bars uses 0000.
  - 1, solid: solid_rgb565.
  - 2, horizontal gradient: R = x[7:3], G = x[7:2], B = 0.
  - 3, checkerboard: 8x8 cells; FFFF if x[3]^y[3], else 0000.
- Width rules: counters are sized from the parameters with no overflow for the defaults; frame_cnt wraps modulo 2^16.

Optional Feature:
Macro OV_GEN_FRAME_SUM_EN.
- Defined: frame_sum accumulates, modulo 2^16, the zero-extended px_data of every href=1 cycle.
  - The accumulator clears on entry to VSYNC.
  - frame_sum is updated with the final value in the same cycle frame_done pulses, and holds until the next frame_done.
- Undefined: no accumulator is built; frame_sum is tied to 0.

Test Plan:
1. Reset: assert rst mid-ACTIVE -> outputs 0 asynchronously (within the same timestep), state IDLE, frame_cnt=0. Release with enable=0 -> outputs stay 0.
2. Frame timing: enable=1, pattern 0 -> vsync high exactly 1488 cycles. First href rise 9920 cycles after vsync rise. 144 href pulses of 352 cycles each, spaced 496 cycles. frame_done after 86304 cycles; frame_cnt=1.
3. Colour bars, line 0 -> bytes FF,FF (x0..21) then FF,E0 at x=22. Bytes F8,00 at x=110. Bytes 00,00 at x=175.
4. Solid 0xF800, pattern change to 3 during ACTIVE -> every active byte pair stays F8,00 until the next frame. The next frame shows the checkerboard (pair FF,FF at x=8, y=0).
5. Drop enable at line 50 of ACTIVE -> frame completes, frame_done pulses once, FSM enters IDLE, vsync stays 0 thereafter.
6. With OV_GEN_FRAME_SUM_EN, solid 0xF800 -> frame_sum=0xE800 at frame_done (25344*0xF8 mod 2^16). Without the macro -> frame_sum=0.

Source files
------------

// File: rtl/ov7670_stream_gen.sv
// OV7670-style RGB565 stream source (vsync/href/px_data) with four test patterns.
// Define OV_GEN_FRAME_SUM_EN to build the per-frame byte checksum on frame_sum.
module ov7670_stream_gen #(
  parameter int H_ACT    = 176,
  parameter int V_ACT    = 144,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb565,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [15:0] frame_sum
);
  localparam int LINE_T    = 2 * H_ACT + H_BLANK;
  localparam int M1        = (VS_LINES > V_BP) ? VS_LINES : V_BP;
  localparam int M2        = (V_ACT > V_FP) ? V_ACT : V_FP;
  localparam int MAX_LINES = (M1 > M2) ? M1 : M2;
  // x needs bit 7 for the gradient and y needs bit 3 for the checkerboard
  localparam int XW_RAW    = $clog2(LINE_T);
  localparam int XW        = (XW_RAW > 9) ? XW_RAW : 9;
  localparam int YW_RAW    = $clog2(MAX_LINES);
  localparam int YW        = (YW_RAW > 4) ? YW_RAW : 4;
  localparam int BAR_W     = (H_ACT >= 8) ? H_ACT / 8 : 1;

  localparam logic [XW-1:0] BYTE_LAST = XW'(LINE_T - 1);
  localparam logic [XW-1:0] ACT_BYTES = XW'(2 * H_ACT);
  localparam logic [15:0] BAR_COLORS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] byte_x_q, byte_x_d;
  logic [YW-1:0] line_y_q, line_y_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [YW-1:0] seg_last;
  logic          byte_last;
  logic          seg_end;
  logic          start;

  always_comb begin
    seg_last = '0;
    case (state_q)
      VSYNC:   seg_last = YW'(VS_LINES - 1);
      VBP:     seg_last = YW'(V_BP - 1);
      ACTIVE:  seg_last = YW'(V_ACT - 1);
      VFP:     seg_last = YW'(V_FP - 1);
      default: seg_last = '0;
    endcase
  end

  assign byte_last = (byte_x_q == BYTE_LAST);
  assign seg_end   = byte_last && (line_y_q == seg_last);

  always_comb begin
    state_d     = state_q;
    byte_x_d    = byte_last ? '0 : byte_x_q + 1'b1;
    line_y_d    = byte_last ? line_y_q + 1'b1 : line_y_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    frame_cnt_d = frame_cnt_q;
    frame_done  = 1'b0;
    start       = 1'b0;
    case (state_q)
      IDLE: begin
        byte_x_d = '0;
        line_y_d = '0;
        start    = enable;
      end
      VSYNC: if (seg_end) begin
        state_d  = VBP;
        line_y_d = '0;
      end
      VBP: if (seg_end) begin
        state_d  = ACTIVE;
        line_y_d = '0;
      end
      ACTIVE: if (seg_end) begin
        state_d  = VFP;
        line_y_d = '0;
      end
      VFP: if (seg_end) begin
        frame_done  = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        line_y_d    = '0;
        state_d     = IDLE;
        start       = enable;
      end
      default: state_d = IDLE;
    endcase
    // Pattern inputs are frozen for the whole frame at the VSYNC entry point
    if (start) begin
      state_d  = VSYNC;
      byte_x_d = '0;
      line_y_d = '0;
      pat_d    = pattern_sel;
      solid_d  = solid_rgb565;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_x_q    <= '0;
      line_y_q    <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_x_q    <= byte_x_d;
      line_y_q    <= line_y_d;
      pat_q       <= pat_d;
      solid_q     <= solid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  logic [XW-2:0] pix_x;
  logic [XW-2:0] bar;
  logic [15:0]   rgb;

  assign pix_x = byte_x_q[XW-1:1];
  assign bar   = pix_x / (XW-1)'(BAR_W);

  always_comb begin
    rgb = 16'h0000;
    case (pat_q)
      2'd0:    rgb = (bar < (XW-1)'(8)) ? BAR_COLORS[bar[2:0]] : 16'h0000;
      2'd1:    rgb = solid_q;
      2'd2:    rgb = {pix_x[7:3], pix_x[7:2], 5'd0};
      default: rgb = (pix_x[3] ^ line_y_q[3]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  assign vsync     = (state_q == VSYNC);
  assign href      = (state_q == ACTIVE) && (byte_x_q < ACT_BYTES);
  assign px_data   = href ? (byte_x_q[0] ? rgb[7:0] : rgb[15:8]) : 8'h00;
  assign frame_cnt = frame_cnt_q;

`ifdef OV_GEN_FRAME_SUM_EN
  logic [15:0] acc_q, acc_d, sum_q, sum_d;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (start) acc_d = '0;
    else if (href) acc_d = acc_q + {8'h00, px_data};
    if (frame_done) sum_d = acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  // The finished sum is already visible during the frame_done cycle itself
  assign frame_sum = frame_done ? acc_q : sum_q;
`else
  assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Randomized self-checking bench for ov7670_stream_gen, run with a short frame geometry.
// Expected stream is derived from frame-relative cycle arithmetic and the pattern rules.
module tb_ov7670_stream_gen;
  localparam int H_ACT     = 176;
  localparam int V_ACT     = 10;
  localparam int H_BLANK   = 144;
  localparam int VS_LINES  = 2;
  localparam int V_BP      = 3;
  localparam int V_FP      = 2;
  localparam int LINE_T    = 2 * H_ACT + H_BLANK;
  localparam int ACT_START = VS_LINES + V_BP;
  localparam int FRAME_T   = (VS_LINES + V_BP + V_ACT + V_FP) * LINE_T;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb565;
  logic        vsync, href, frame_done;
  logic [7:0]  px_data;
  logic [15:0] frame_cnt, frame_sum;

  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  logic [15:0] prev_sum = 16'h0000;
  logic [7:0]  line_buf [2*H_ACT];

  ov7670_stream_gen #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK),
    .VS_LINES(VS_LINES), .V_BP(V_BP), .V_FP(V_FP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb565(solid_rgb565), .vsync(vsync), .href(href), .px_data(px_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_rgb(input int pat, input logic [15:0] solid,
                                            input int x, input int y);
    logic [15:0] c;
    c = 16'h0000;
    case (pat)
      0: case (x / (H_ACT / 8))
           0: c = 16'hFFFF;
           1: c = 16'hFFE0;
           2: c = 16'h07FF;
           3: c = 16'h07E0;
           4: c = 16'hF81F;
           5: c = 16'hF800;
           6: c = 16'h001F;
           default: c = 16'h0000;
         endcase
      1: c = solid;
      2: c = 16'(((x >> 3) % 32) * 2048 + ((x >> 2) % 64) * 32);
      default: c = ((((x / 8) + (y / 8)) % 2) == 1) ? 16'hFFFF : 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] model_byte(input int pat, input logic [15:0] solid,
                                            input int col, input int y);
    logic [15:0] c;
    c = model_rgb(pat, solid, col / 2, y);
    return ((col % 2) == 0) ? c[15:8] : c[7:0];
  endfunction

  function automatic logic [15:0] model_frame_sum(input int pat, input logic [15:0] solid);
    int s;
    s = 0;
    for (int y = 0; y < V_ACT; y++)
      for (int c = 0; c < 2 * H_ACT; c++)
        s += int'(model_byte(pat, solid, c, y));
    return 16'(s);
  endfunction

  function automatic logic [15:0] exp_sum_out(input logic [15:0] s);
`ifdef OV_GEN_FRAME_SUM_EN
    return s;
`else
    return (s & 16'h0000);
`endif
  endfunction

  // Enters at a negedge; the following posedge starts the frame.
  task automatic check_frame(input string name, input logic [1:0] pat, input logic [15:0] solid,
                             input int drop_line, input int pert_line, input logic [1:0] pert_pat,
                             input logic [15:0] pert_solid, input logic keep);
    int ln, col, y, sum;
    logic e_vs, e_href, e_done;
    logic [7:0] e_px;
    logic [26:0] got, exp;
    bit bad;
    sum = 0;
    bad = 0;
    pattern_sel  = pat;
    solid_rgb565 = solid;
    enable       = 1'b1;
    @(posedge clk);
    for (int t = 0; t < FRAME_T; t++) begin
      @(negedge clk);
      ln     = t / LINE_T;
      col    = t % LINE_T;
      y      = ln - ACT_START;
      e_vs   = (ln < VS_LINES);
      e_href = (y >= 0) && (y < V_ACT) && (col < 2 * H_ACT);
      e_px   = e_href ? model_byte(int'(pat), solid, col, y) : 8'h00;
      if (e_href) sum += int'(e_px);
      e_done = (t == FRAME_T - 1);
      exp = {e_vs, e_href, e_done, e_px, e_done ? exp_sum_out(16'(sum)) : exp_sum_out(prev_sum)};
      got = {vsync, href, frame_done, px_data, frame_sum};
      if (!bad) begin
        checks++;
        if (got !== exp) begin
          errors++;
          bad = 1;
          $display("[TB] FAIL %s_stream t=%0d {vs,href,done,px,sum} got=%h expected=%h",
                   name, t, got, exp);
        end
      end
      if (e_href && y == 0) line_buf[col] = px_data;
      if (e_done) begin
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
          errors++;
          $display("[TB] FAIL %s_cnt_at_done got=%0d expected=%0d", name, frame_cnt, exp_frames);
        end
      end
      if (y == pert_line && col == 0) begin
        pattern_sel  = pert_pat;
        solid_rgb565 = pert_solid;
      end
      if (drop_line >= 0) enable = (y < drop_line);
      else enable = 1'($urandom);
      if (e_done) enable = keep;
    end
    exp_frames++;
    prev_sum = 16'(sum);
  endtask

  task automatic check_idle(input string name, input int cycles);
    logic [42:0] v;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      v = {vsync, href, frame_done, px_data, frame_cnt, frame_sum};
      checks++;
      if (v !== {3'b000, 8'h00, 16'(exp_frames), exp_sum_out(prev_sum)}) begin
        errors++;
        $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, i, v,
                 {3'b000, 8'h00, 16'(exp_frames), exp_sum_out(prev_sum)});
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [42:0] v;
    rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb565 = 16'h0000;
    repeat (3) @(negedge clk);
    v = {vsync, href, frame_done, px_data, frame_cnt, frame_sum};
    checks++;
    if (v !== 43'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold got=%h expected=0", v);
    end
    rst = 1'b0;
    check_idle("idle_after_reset", 20);
  endtask

  task automatic test_frame_timing();
    int vs_first, vs_cnt, vs_after, n_href, first_rise, last_rise, width, bad_w, bad_sp;
    int done_cnt, done_t, idx;
    logic prev_href;
    vs_first = -1; vs_cnt = 0; vs_after = 0; n_href = 0; first_rise = -1; last_rise = -1;
    width = 0; bad_w = 0; bad_sp = 0; done_cnt = 0; done_t = -1; prev_href = 1'b0;
    pattern_sel = 2'd0; solid_rgb565 = 16'($urandom); enable = 1'b1;
    @(posedge clk);
    for (int t = 0; t < FRAME_T + LINE_T; t++) begin
      @(negedge clk);
      if (t == 0) enable = 1'b0;
      if (vsync) begin
        if (vs_first < 0) vs_first = t;
        vs_cnt++;
        if (done_t >= 0) vs_after++;
      end
      if (href) width++;
      if (href && !prev_href) begin
        n_href++;
        if (first_rise < 0) first_rise = t;
        else if (t - last_rise != LINE_T) bad_sp++;
        last_rise = t;
      end
      if (!href && prev_href) begin
        if (width != 2 * H_ACT) bad_w++;
        width = 0;
      end
      idx = t - first_rise;
      if (href && n_href == 1 && idx < 2 * H_ACT) line_buf[idx] = px_data;
      if (frame_done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      prev_href = href;
    end
    checks += 11;
    if (vs_first !== 0) begin errors++; $display("[TB] FAIL vsync_rise got=%0d expected=0", vs_first); end
    if (vs_cnt !== VS_LINES * LINE_T) begin errors++; $display("[TB] FAIL vsync_len got=%0d expected=%0d", vs_cnt, VS_LINES * LINE_T); end
    if (vs_after !== 0) begin errors++; $display("[TB] FAIL vsync_after_done got=%0d expected=0", vs_after); end
    if (first_rise - vs_first !== ACT_START * LINE_T) begin errors++; $display("[TB] FAIL href_first got=%0d expected=%0d", first_rise - vs_first, ACT_START * LINE_T); end
    if (n_href !== V_ACT) begin errors++; $display("[TB] FAIL href_pulses got=%0d expected=%0d", n_href, V_ACT); end
    if (bad_w !== 0) begin errors++; $display("[TB] FAIL href_width bad=%0d expected=0", bad_w); end
    if (bad_sp !== 0) begin errors++; $display("[TB] FAIL href_spacing bad=%0d expected=0", bad_sp); end
    if (done_cnt !== 1) begin errors++; $display("[TB] FAIL done_pulses got=%0d expected=1", done_cnt); end
    if (done_t !== FRAME_T - 1) begin errors++; $display("[TB] FAIL done_time got=%0d expected=%0d", done_t, FRAME_T - 1); end
    exp_frames++;
    prev_sum = model_frame_sum(0, 16'h0000);
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("[TB] FAIL timing_cnt got=%0d expected=%0d", frame_cnt, exp_frames); end
    if (frame_sum !== exp_sum_out(prev_sum)) begin errors++; $display("[TB] FAIL timing_sum got=%h expected=%h", frame_sum, exp_sum_out(prev_sum)); end
  endtask

  task automatic test_color_bars();
    int idx [10] = '{0, 1, 42, 43, 44, 45, 220, 221, 350, 351};
    logic [7:0] exb [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hF8, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (line_buf[idx[i]] !== exb[i]) begin
        errors++;
        $display("[TB] FAIL bars_byte%0d got=%h expected=%h", idx[i], line_buf[idx[i]], exb[i]);
      end
    end
  endtask

  task automatic test_hold_pattern();
    check_frame("hold_solid", 2'd1, 16'hF800, -1, 3, 2'd3, 16'($urandom), 1'b1);
    check_frame("hold_checker", 2'd3, 16'($urandom), -1, 5, 2'($urandom), 16'($urandom), 1'b0);
    checks += 2;
    if ({line_buf[16], line_buf[17]} !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL checker_x8 got=%h expected=FFFF", {line_buf[16], line_buf[17]});
    end
    if ({line_buf[0], line_buf[1]} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL checker_x0 got=%h expected=0000", {line_buf[0], line_buf[1]});
    end
    check_idle("idle_after_hold", 4);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++)
      check_frame("random", 2'($urandom), 16'($urandom), -1, int'($urandom_range(0, V_ACT - 1)),
                  2'($urandom), 16'($urandom), f == 0);
    check_idle("idle_after_random", 4);
  endtask

  task automatic test_enable_drop();
    check_frame("drop", 2'($urandom), 16'($urandom), 4, -100, 2'd0, 16'h0000, 1'b0);
    check_idle("idle_after_drop", 2 * LINE_T);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [42:0] v;
    pattern_sel = 2'd0; enable = 1'b1;
    @(posedge clk);
    n = 0;
    while (!href && n < FRAME_T) begin
      @(negedge clk);
      n++;
    end
    if (!href) begin
      checks++; errors++;
      $display("[TB] FAIL reset_wait_href got=timeout expected=href within %0d cycles", FRAME_T);
    end
    repeat (100) @(negedge clk);
    #1 rst = 1'b1;
    enable = 1'b0;
    #1;
    v = {vsync, href, frame_done, px_data, frame_cnt, frame_sum};
    checks++;
    if (v !== 43'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got=%h expected=0", v);
    end
    exp_frames = 0;
    prev_sum = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    check_idle("idle_after_mid_reset", 2 * LINE_T);
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_color_bars();
    test_hold_pattern();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
